// File: rtl/booth_feeder.sv
// booth_feeder: queues signed 4-bit operand pairs and sequences one downstream 4-bit Booth multiplier per pair.
// Latency: 7 cycles from the mul_start cycle to res_valid (17 on timeout); a push reaches mul_start 2 edges later at best.
// Backpressure: in_ready drops while the operand queue is full; a result is held until res_ready takes it.
//
// Ports:
//   clk, rst                      shared clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b   operand pair input (valid/ready)
//   mul_start                     one-cycle start pulse to the multiplier
//   mul_multiplicand/_multiplier  operands, stable from the start cycle until capture
//   mul_busy, mul_p               multiplier status and product register (product in mul_p[8:1])
//   res_valid/res_ready           result handshake
//   res_data, res_err             signed product; err marks a timed-out operation
//
// Build option: define BOOTH_FEEDER_FIFO_EN for a 4-entry operand FIFO;
// otherwise the queue is a single holding register.
module booth_feeder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       mul_start,
    output logic [3:0] mul_multiplicand,
    output logic [3:0] mul_multiplier,
    input  logic       mul_busy,
    input  logic [8:0] mul_p,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_err
);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } opnd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       push;
    logic       pop;
    logic       q_vld;
    opnd_t      q_dat;
    opnd_t      in_dat;
    logic       cap;
    logic [3:0] tmo_cnt;

    // mul_p[0] is the Booth Q-1 guard bit; it is not part of the product.
    logic       unused_p0;
    assign unused_p0 = mul_p[0];

    assign in_dat = {in_a, in_b};
    assign push   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Operand queue
    // ------------------------------------------------------------------
`ifdef BOOTH_FEEDER_FIFO_EN
    localparam int DEPTH = 4;

    opnd_t      mem [DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    // Storage needs no reset: count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // 2-bit pointers wrap naturally at depth 4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // No pass-through: a full queue refuses a push even if it pops this cycle.
    assign in_ready = (count != 3'(DEPTH));
    assign q_vld    = (count != 3'd0);
    assign q_dat    = mem[rd_ptr];
`else
    opnd_t hold_dat;
    logic  hold_vld;

    // push needs an empty register and pop needs a full one, so they never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld <= 1'b0;
            hold_dat <= '0;
        end else if (push) begin
            hold_vld <= 1'b1;
            hold_dat <= in_dat;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end
    end

    assign in_ready = !hold_vld;
    assign q_vld    = hold_vld;
    assign q_dat    = hold_dat;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    // Capture when the multiplier is done, or give up after 16 WAIT cycles.
    assign cap = (state == WAIT) && (!mul_busy || (tmo_cnt == 4'hF));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (q_vld) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cap) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // The next operand issues on the same edge that takes the result.
                if (res_valid && res_ready) begin
                    if (q_vld) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mul_start = (state == START);

    // ------------------------------------------------------------------
    // Operand, timeout and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            tmo_cnt          <= '0;
            res_valid        <= 1'b0;
            res_data         <= '0;
            res_err          <= 1'b0;
        end else begin
            // Operands only change on a pop, which never happens between start and capture.
            if (pop) begin
                mul_multiplicand <= q_dat.a;
                mul_multiplier   <= q_dat.b;
            end

            if (state == START) begin
                tmo_cnt <= '0;
            end else if ((state == WAIT) && (tmo_cnt != 4'hF)) begin
                tmo_cnt <= tmo_cnt + 4'd1;
            end

            // Capture only happens in WAIT, where res_valid is already low,
            // so data/err never move under a pending result.
            if (cap) begin
                res_data  <= mul_p[8:1];
                res_err   <= mul_busy;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_booth_feeder.sv
`timescale 1ns/1ps
module tb_booth_feeder;

`ifdef BOOTH_FEEDER_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = 4'h0;
    logic [3:0] in_b = 4'h0;
    logic       mul_start;
    logic [3:0] mul_multiplicand;
    logic [3:0] mul_multiplier;
    logic       mul_busy = 1'b0;
    logic [8:0] mul_p = 9'h000;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_err;

    booth_feeder dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_busy         (mul_busy),
        .mul_p            (mul_p),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_err          (res_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Signed 4x4 product computed with plain integer arithmetic.
    function automatic int sx4(logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic logic [7:0] prod(logic [3:0] a, logic [3:0] b);
        int r;
        r = sx4(a) * sx4(b);
        return r[7:0];
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] v;
        do v = 4'($urandom_range(0, 15)); while (v == 4'h8);
        return v;
    endfunction

    // Behavioural multiplier: busy on the start edge, four step edges with
    // scrambled partial products, busy falls with the product in p[8:1].
    // When stuck, busy never falls and p holds a fixed pattern.
    logic       stuck = 1'b0;
    int         steps = 0;
    logic [3:0] op_a = 4'h0;
    logic [3:0] op_b = 4'h0;

    always @(posedge clk) begin
        if (mul_start) begin
            mul_busy <= 1'b1;
            steps    <= 0;
            op_a     <= mul_multiplicand;
            op_b     <= mul_multiplier;
            mul_p    <= stuck ? 9'h1A5 : 9'($urandom);
        end else if (mul_busy && !stuck) begin
            if (steps == 4) begin
                mul_busy <= 1'b0;
                mul_p    <= {prod(op_a, op_b), 1'b0};
            end else begin
                steps <= steps + 1;
                mul_p <= 9'($urandom);
            end
        end
    end

    // Reference model: operands waiting to issue, and results expected in order.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } pair_t;

    typedef struct packed {
        logic [7:0] d;
        logic       e;
        logic [7:0] lat;
    } exp_t;

    pair_t issue_q[$];
    exp_t  res_q[$];

    int cyc        = 0;
    int last_start = 0;
    int rel_cyc    = 0;
    int n_starts   = 0;
    int n_takes    = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: note handshakes before the edge, then check after it.
    task automatic tick();
        logic       pushed, took, prev_valid, prev_err, prev_start;
        logic [7:0] prev_data;
        int         queued;
        pair_t      p;
        exp_t       e;
        pushed     = in_valid && in_ready;
        took       = res_valid && res_ready;
        queued     = issue_q.size();
        prev_valid = res_valid;
        prev_data  = res_data;
        prev_err   = res_err;
        prev_start = mul_start;
        if (pushed) begin
            p.a = in_a;
            p.b = in_b;
            issue_q.push_back(p);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;

        if (mul_start) begin
            n_starts++;
            last_start = cyc;
            chk("start_one_cycle", 32'(prev_start), 32'd0);
            chk("start_has_operand", 32'(issue_q.size() != 0), 32'd1);
            if (issue_q.size() != 0) begin
                p = issue_q.pop_front();
                chk("start_operands", 32'({mul_multiplicand, mul_multiplier}), 32'({p.a, p.b}));
                e.d   = stuck ? 8'hD2 : prod(p.a, p.b);
                e.e   = stuck;
                e.lat = stuck ? 8'd17 : 8'd7;
                res_q.push_back(e);
            end
        end

        if (took) begin
            n_takes++;
            if (res_q.size() != 0) void'(res_q.pop_front());
            chk("valid_clears", 32'(res_valid), 32'd0);
            chk("issue_on_take", 32'(mul_start), 32'(queued != 0));
        end else if (prev_valid) begin
            chk("hold_stable", 32'({res_valid, res_err, res_data}), 32'({1'b1, prev_err, prev_data}));
        end

        if (res_valid && !prev_valid) begin
            chk("result_pending", 32'(res_q.size() != 0), 32'd1);
            if (res_q.size() != 0) begin
                chk("res_data", 32'(res_data), 32'(res_q[0].d));
                chk("res_err", 32'(res_err), 32'(res_q[0].e));
                chk("latency", 32'(cyc - last_start), 32'(res_q[0].lat));
            end
        end

        chk("in_ready", 32'(in_ready), 32'(issue_q.size() < DEPTH));
    endtask

    task automatic push(logic [3:0] a, logic [3:0] b);
        logic acc;
        int   g;
        g        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        do begin
            acc = in_ready;
            tick();
            g++;
        end while (!acc && g < 200);
        chk("push_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(int limit);
        int g;
        g = 0;
        while ((issue_q.size() != 0 || res_q.size() != 0 || res_valid) && g < limit) begin
            tick();
            g++;
        end
        chk("drain_done", 32'(g < limit), 32'd1);
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_err"}, 32'(res_err), 32'd0);
        chk({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_operands"}, 32'({mul_multiplicand, mul_multiplier}), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        reset_checks("rst_async");
        issue_q.delete();
        res_q.delete();
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        rel_cyc = cyc;
    endtask

    initial begin
        int g;
        int s0;
        int t0;

        // Reset values.
        #1;
        reset_checks("por");
        chk("por_res_data", 32'(res_data), 32'd0);
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        rel_cyc = cyc;

        // Single op straight out of reset: earliest start is the second edge.
        res_ready = 1'b1;
        push(4'h3, 4'h5);
        tick();
        chk("first_start_seen", 32'(mul_start), 32'd1);
        chk("first_start_edge", 32'(cyc - rel_cyc), 32'd2);
        g = 0;
        while (!res_valid && g < 40) begin tick(); g++; end
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data", 32'(res_data), 32'h0F);
        drain(100);

        // Signed operands.
        push(4'hD, 4'h5);
        push(4'h7, 4'h8);
        drain(200);

        // Backpressure: hold the first result, fill the queue behind it.
        res_ready = 1'b0;
        push(4'h2, 4'h3);
        g = 0;
        while (!res_valid && g < 40) begin tick(); g++; end
        chk("bp_valid", 32'(res_valid), 32'd1);
        for (int i = 0; i < DEPTH; i++) push(rand_op(), rand_op());
        chk("bp_full", 32'(in_ready), 32'd0);
        s0 = n_starts;
        repeat (20) tick();
        chk("bp_no_start", 32'(n_starts - s0), 32'd0);
        chk("bp_data", 32'(res_data), 32'h06);
        res_ready = 1'b1;
        drain(400);

        // Timeout with busy stuck high.
        stuck = 1'b1;
        push(4'h5, 4'h5);
        g = 0;
        while (!res_valid && g < 60) begin tick(); g++; end
        chk("tmo_valid", 32'(res_valid), 32'd1);
        chk("tmo_err", 32'(res_err), 32'd1);
        chk("tmo_latency", 32'(cyc - last_start), 32'd17);
        drain(100);
        stuck = 1'b0;

        // Reset during WAIT with queued operands.
        push(4'h3, 4'h3);
        for (int i = 0; i < ((DEPTH < 2) ? DEPTH : 2); i++) push(rand_op(), rand_op());
        g = 0;
        while ((cyc - last_start < 3 || res_valid) && g < 40) begin tick(); g++; end
        chk("rmid_in_wait", 32'(res_valid || mul_start), 32'd0);
        do_reset();
        s0 = n_starts;
        repeat (30) tick();
        chk("rmid_no_start", 32'(n_starts - s0), 32'd0);
        chk("rmid_no_result", 32'(res_valid), 32'd0);
        push(4'h6, 4'h7);
        drain(100);

        // Back-to-back pairs, consumer always ready.
        t0 = n_takes;
        push(4'h1, 4'h1);
        push(4'hF, 4'hF);
        push(4'h7, 4'h7);
        push(4'h4, 4'hE);
        drain(300);
        chk("b2b_takes", 32'(n_takes - t0), 32'd4);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = rand_op();
            in_b      = rand_op();
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        drain(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/booth_feeder.md
BOOTH_FEEDER -- requirements
Module: booth_feeder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock shared with the downstream 4-bit Booth multiplier.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  operand pair present on in_a/in_b.
REQ-005 in_ready  output  1  operand pair accepted when in_valid && in_ready at a rising edge.
REQ-006 in_a  input  4  signed multiplicand.
REQ-007 in_b  input  4  signed multiplier.
REQ-008 mul_start  output  1  start pulse to the multiplier.
REQ-009 mul_multiplicand  output  4  operand held stable from the start cycle until capture.
REQ-010 mul_multiplier  output  4  operand held stable from the start cycle until capture.
REQ-011 mul_busy  input  1  multiplier busy flag.
REQ-012 mul_p  input  9  multiplier product register.
REQ-013 res_valid  output  1  result register holds an untaken result.
REQ-014 res_ready  input  1  consumer takes the result when res_valid && res_ready.
REQ-015 res_data  output  8  signed product.
REQ-016 res_err  output  1  set with res_valid when the operation timed out.

Function
REQ-017 The FSM SHALL have four states: IDLE, START, WAIT, HOLD.
REQ-018 IDLE -> START when an operand is queued; on that transition, pop the entry onto mul_multiplicand/mul_multiplier.
REQ-019 In START, mul_start SHALL be 1 for exactly one cycle; START -> WAIT unconditionally.
REQ-020 In WAIT, a 4-bit timeout counter SHALL start at 0 and increment each cycle.
REQ-021 In WAIT with mul_busy==0: capture res_data=mul_p[8:1], set res_err=0, set res_valid=1, then go to HOLD.
REQ-022 In WAIT with the counter at 15 and mul_busy still 1: capture mul_p[8:1], set res_err=1, set res_valid=1, then go to HOLD.
REQ-023 Nominal latency SHALL be 7 cycles from the START cycle to res_valid=1 (start edge, 4 Booth steps, busy fall, capture).
REQ-024 HOLD: when res_valid && res_ready, clear res_valid.
REQ-025 HOLD exits when the result is taken: to START if an operand is queued (issue in the same cycle as the take), otherwise to IDLE.
REQ-026 res_data/res_err SHALL NOT change while res_valid==1.
REQ-027 in_ready SHALL be 1 exactly when the operand queue is not full; a push on a full queue is not allowed (no pass-through).
REQ-028 A push and a pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-029 A push to an empty queue is visible to IDLE on the next cycle (1-cycle minimum input-to-start).
REQ-030 Queue pointers SHALL wrap modulo depth.
REQ-031 Operands SHALL be forwarded unmodified; in_a==4'h8 is outside the multiplier's range and its result is unspecified.

Reset
REQ-032 On rst, the block SHALL asynchronously enter IDLE.
REQ-033 Reset values: mul_start=0, res_valid=0, res_err=0, res_data=0, mul_multiplicand=0, mul_multiplier=0, timeout counter=0, queue emptied, in_ready=1.
REQ-034 Reset mid-operation SHALL discard the in-flight operation and all queued operands; the multiplier is not reset, and the next mul_start reinitialises it.
REQ-035 The first mul_start SHALL occur no earlier than the second rising edge after rst deasserts.

Configuration
REQ-036 BOOTH_FEEDER_FIFO_EN defined: the operand queue SHALL be a 4-entry FIFO.
REQ-037 BOOTH_FEEDER_FIFO_EN undefined: the operand queue SHALL be a single holding register (depth 1), with in_ready=0 while it is occupied.
REQ-038 All other behaviour SHALL be identical in both builds.

Verification
REQ-039 Single op: in_a=4'h3, in_b=4'h5 -> res_data=8'h0F, res_err=0, res_valid rising 7 cycles after mul_start.
REQ-040 Signed op: in_a=4'hD (-3), in_b=4'h5 -> res_data=8'hF1; in_a=4'h7, in_b=4'h8 (-8) -> res_data=8'hC8.
REQ-041 Backpressure: res_ready=0 for 20 cycles after the first result -> res_data stable, no second mul_start, in_ready falls when the queue fills (after 4 pushes with FIFO_EN, after 1 without).
REQ-042 Timeout: mul_busy stuck at 1 -> res_valid=1 with res_err=1 exactly 16 cycles after entering WAIT.
REQ-043 Reset mid-op: assert rst during WAIT with 2 entries queued -> res_valid=0, in_ready=1, and no further mul_start until a new push.
REQ-044 Back-to-back: 4 pairs pushed on consecutive cycles with res_ready=1 -> 4 in-order correct results, each mul_start issued in the same cycle as the previous result's take.
